// File: rtl/uart_transmitter_if.sv
// Byte-producer handshake into the UART transmitter.
// The master offers a byte with valid; the slave accepts it while ready is high.
interface uart_transmitter_if;
    logic [7:0] data_in;
    logic       data_in_valid;
    logic       data_in_ready;

    modport master (
        output data_in,
        output data_in_valid,
        input  data_in_ready
    );

    modport slave (
        input  data_in,
        input  data_in_valid,
        output data_in_ready
    );
endinterface

// File: rtl/uart_transmitter.sv
// 8N1 UART transmitter: one start bit, eight data bits LSB first, one stop bit.
// Every symbol is held for CLOCK_FREQ/BAUD_RATE clocks, and the line is driven from a flop.
module uart_transmitter #(
    parameter int unsigned CLOCK_FREQ = 125_000_000,
    parameter int unsigned BAUD_RATE  = 115_200
) (
    input  logic                clk,
    input  logic                rst,
    uart_transmitter_if.slave   tx_if,
    output logic                serial_out
);

    localparam int unsigned T     = CLOCK_FREQ / BAUD_RATE;
    localparam int unsigned CNT_W = (T < 2) ? 1 : $clog2(T);

    generate
        if (T < 2) begin : g_bad_rate
            $error("uart_transmitter: CLOCK_FREQ/BAUD_RATE must be at least 2");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    state_t             state_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [CNT_W-1:0]   cnt_d;
    logic [2:0]         bit_q;
    logic [2:0]         bit_d;
    logic [7:0]         shift_q;
    logic               serial_q;
    logic               ready_q;
    logic               sym_end;
    logic               accept;

    assign sym_end = (cnt_q == CNT_W'(T - 1));
    assign accept  = tx_if.data_in_valid && ready_q;

    // Cycle counter runs only while a frame is on the line and wraps at each symbol boundary.
    always_comb begin
        cnt_d = cnt_q;
        bit_d = bit_q;
        if (state_q != IDLE) begin
            if (sym_end) begin
                cnt_d = '0;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
        if (state_q == DATA && sym_end) begin
            bit_d = (bit_q == 3'd7) ? 3'd0 : bit_q + 3'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            bit_q    <= '0;
            shift_q  <= '0;
            serial_q <= 1'b1;
            ready_q  <= 1'b1;
        end else begin
            cnt_q <= cnt_d;
            bit_q <= bit_d;
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        state_q  <= START;
                        shift_q  <= tx_if.data_in;
                        serial_q <= 1'b0;
                        ready_q  <= 1'b0;
                        cnt_q    <= '0;
                    end
                end
                START: begin
                    if (sym_end) begin
                        state_q  <= DATA;
                        serial_q <= shift_q[0];
                        shift_q  <= {1'b0, shift_q[7:1]};
                    end
                end
                // Shifter always holds the next bit to send in its LSB.
                DATA: begin
                    if (sym_end) begin
                        if (bit_q == 3'd7) begin
                            state_q  <= STOP;
                            serial_q <= 1'b1;
                        end else begin
                            serial_q <= shift_q[0];
                            shift_q  <= {1'b0, shift_q[7:1]};
                        end
                    end
                end
                STOP: begin
                    if (sym_end) begin
                        state_q <= IDLE;
                        ready_q <= 1'b1;
                    end
                end
            endcase
        end
    end

    assign tx_if.data_in_ready = ready_q;
    assign serial_out          = serial_q;

endmodule

// File: tb/tb_uart_transmitter.sv
// Self-checking bench for uart_transmitter at T=10 using a byte scoreboard.
module tb_uart_transmitter;

    localparam int T = 10;

    logic clk;
    logic rst;
    logic serial_out;
    int   errors;
    int   checks;
    logic [7:0] sb_q[$];

    uart_transmitter_if u_if ();

    uart_transmitter #(
        .CLOCK_FREQ (1000),
        .BAUD_RATE  (100)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .tx_if      (u_if),
        .serial_out (serial_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic send(input logic [7:0] b, input bit keep_valid);
        bit got;
        got = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (u_if.data_in_ready === 1'b1) begin
                got = 1'b1;
                break;
            end
        end
        checks++;
        if (!got) begin
            errors++;
            $display("FAIL send_wait: data_in_ready stayed low for 200 cycles, required 1");
        end
        u_if.data_in       = b;
        u_if.data_in_valid = 1'b1;
        @(posedge clk);
        sb_q.push_back(b);
        #1;
        if (!keep_valid) u_if.data_in_valid = 1'b0;
    endtask

    // Samples 10 symbols' worth of line cycles, optionally disturbing the inputs meanwhile.
    task automatic capture(input int inj_from, input int inj_to, input logic [7:0] inj_data,
                           input bit toggle, output logic [9:0] sym, output logic [9:0] stab,
                           output int rdy_low);
        int idx;
        sym     = '0;
        stab    = '1;
        rdy_low = 0;
        for (int c = 0; c < 10 * T; c++) begin
            @(negedge clk);
            idx = c / T;
            if (c % T == 0) sym[idx] = serial_out;
            else if (serial_out !== sym[idx]) stab[idx] = 1'b0;
            if (u_if.data_in_ready === 1'b0) rdy_low++;
            if (toggle) u_if.data_in = ~u_if.data_in;
            if (inj_from >= 0) begin
                if (c >= inj_from && c <= inj_to) begin
                    u_if.data_in_valid = 1'b1;
                    u_if.data_in       = inj_data;
                end else begin
                    u_if.data_in_valid = 1'b0;
                end
            end
        end
    endtask

    task automatic test_reset;
        int bad_s;
        int bad_r;
        rst                = 1'b1;
        u_if.data_in_valid = 1'b0;
        u_if.data_in       = 8'h00;
        #1;
        checks++;
        if (serial_out !== 1'b1) begin
            errors++;
            $display("FAIL reset_serial: got %b required 1", serial_out);
        end
        repeat (3) @(negedge clk);
        checks++;
        if (u_if.data_in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_ready: got %b required 1", u_if.data_in_ready);
        end
        rst   = 1'b0;
        bad_s = 0;
        bad_r = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (serial_out !== 1'b1) bad_s++;
            if (u_if.data_in_ready !== 1'b1) bad_r++;
        end
        checks++;
        if (bad_s != 0) begin
            errors++;
            $display("FAIL reset_idle_line: %0d non-high cycles, required 0", bad_s);
        end
        checks++;
        if (bad_r != 0) begin
            errors++;
            $display("FAIL reset_idle_ready: %0d not-ready cycles, required 0", bad_r);
        end
    endtask

    task automatic test_a5;
        logic [9:0] sym;
        logic [9:0] stab;
        logic [9:0] exp;
        logic [7:0] want;
        int rl;
        send(8'hA5, 1'b0);
        capture(-1, -1, 8'h00, 1'b0, sym, stab, rl);
        exp = {1'b1, 8'hA5, 1'b0};
        for (int s = 0; s < 10; s++) begin
            checks++;
            if (sym[s] !== exp[s] || stab[s] !== 1'b1) begin
                errors++;
                $display("FAIL a5_symbol%0d: level=%b held=%b required level=%b held=1", s, sym[s], stab[s], exp[s]);
            end
        end
        checks++;
        if (rl != 100) begin
            errors++;
            $display("FAIL a5_ready_low: %0d cycles, required 100", rl);
        end
        @(negedge clk);
        checks++;
        if (u_if.data_in_ready !== 1'b1 || serial_out !== 1'b1) begin
            errors++;
            $display("FAIL a5_return_idle: ready=%b line=%b required 1/1", u_if.data_in_ready, serial_out);
        end
        want = (sb_q.size() > 0) ? sb_q.pop_front() : 8'hxx;
        checks++;
        if (sym[8:1] !== want) begin
            errors++;
            $display("FAIL a5_byte: got %h required %h", sym[8:1], want);
        end
    endtask

    task automatic test_ignore_busy;
        logic [9:0] sym;
        logic [9:0] stab;
        logic [9:0] exp;
        logic [7:0] want;
        int rl;
        int bad;
        send(8'h3C, 1'b0);
        // Offer 0xFF for the whole of data bit 4 while busy.
        capture(5 * T, 6 * T - 1, 8'hFF, 1'b0, sym, stab, rl);
        exp = {1'b1, 8'h3C, 1'b0};
        for (int s = 0; s < 10; s++) begin
            checks++;
            if (sym[s] !== exp[s] || stab[s] !== 1'b1) begin
                errors++;
                $display("FAIL ignore_symbol%0d: level=%b held=%b required level=%b held=1", s, sym[s], stab[s], exp[s]);
            end
        end
        want = (sb_q.size() > 0) ? sb_q.pop_front() : 8'hxx;
        checks++;
        if (sym[8:1] !== want) begin
            errors++;
            $display("FAIL ignore_byte: got %h required %h", sym[8:1], want);
        end
        bad = 0;
        for (int i = 0; i < 3 * T; i++) begin
            @(negedge clk);
            if (serial_out !== 1'b1 || u_if.data_in_ready !== 1'b1) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL ignore_no_second_frame: %0d busy/low cycles, required 0", bad);
        end
    endtask

    task automatic test_back_to_back;
        logic [9:0] sym;
        logic [9:0] stab;
        logic [9:0] exp;
        logic [7:0] want;
        int rl;
        send(8'h00, 1'b1);
        u_if.data_in = 8'hFF;
        capture(-1, -1, 8'h00, 1'b0, sym, stab, rl);
        exp = {1'b1, 8'h00, 1'b0};
        for (int s = 0; s < 10; s++) begin
            checks++;
            if (sym[s] !== exp[s] || stab[s] !== 1'b1) begin
                errors++;
                $display("FAIL b2b_first_symbol%0d: level=%b held=%b required level=%b held=1", s, sym[s], stab[s], exp[s]);
            end
        end
        want = (sb_q.size() > 0) ? sb_q.pop_front() : 8'hxx;
        checks++;
        if (sym[8:1] !== want) begin
            errors++;
            $display("FAIL b2b_first_byte: got %h required %h", sym[8:1], want);
        end
        @(negedge clk);
        checks++;
        if (serial_out !== 1'b1 || u_if.data_in_ready !== 1'b1) begin
            errors++;
            $display("FAIL b2b_idle_gap: line=%b ready=%b required 1/1", serial_out, u_if.data_in_ready);
        end
        @(posedge clk);
        sb_q.push_back(8'hFF);
        #1;
        u_if.data_in_valid = 1'b0;
        capture(-1, -1, 8'h00, 1'b0, sym, stab, rl);
        exp = {1'b1, 8'hFF, 1'b0};
        for (int s = 0; s < 10; s++) begin
            checks++;
            if (sym[s] !== exp[s] || stab[s] !== 1'b1) begin
                errors++;
                $display("FAIL b2b_second_symbol%0d: level=%b held=%b required level=%b held=1", s, sym[s], stab[s], exp[s]);
            end
        end
        want = (sb_q.size() > 0) ? sb_q.pop_front() : 8'hxx;
        checks++;
        if (sym[8:1] !== want) begin
            errors++;
            $display("FAIL b2b_second_byte: got %h required %h", sym[8:1], want);
        end
    endtask

    task automatic test_async_reset;
        logic [9:0] sym;
        logic [9:0] stab;
        logic [9:0] exp;
        logic [7:0] want;
        int rl;
        send(8'h00, 1'b0);
        // Stop mid data bit 3, then assert reset between clock edges.
        repeat (4 * T + 5) @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if (serial_out !== 1'b1 || u_if.data_in_ready !== 1'b1) begin
            errors++;
            $display("FAIL async_reset: line=%b ready=%b required 1/1 before next edge", serial_out, u_if.data_in_ready);
        end
        if (sb_q.size() > 0) void'(sb_q.pop_front());
        u_if.data_in       = 8'h81;
        u_if.data_in_valid = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        sb_q.push_back(8'h81);
        #1;
        u_if.data_in_valid = 1'b0;
        capture(-1, -1, 8'h00, 1'b0, sym, stab, rl);
        exp = {1'b1, 8'h81, 1'b0};
        for (int s = 0; s < 10; s++) begin
            checks++;
            if (sym[s] !== exp[s] || stab[s] !== 1'b1) begin
                errors++;
                $display("FAIL post_reset_symbol%0d: level=%b held=%b required level=%b held=1", s, sym[s], stab[s], exp[s]);
            end
        end
        want = (sb_q.size() > 0) ? sb_q.pop_front() : 8'hxx;
        checks++;
        if (sym[8:1] !== want) begin
            errors++;
            $display("FAIL post_reset_byte: got %h required %h", sym[8:1], want);
        end
    endtask

    task automatic test_data_toggle;
        logic [9:0] sym;
        logic [9:0] stab;
        logic [9:0] exp;
        logic [7:0] want;
        int rl;
        send(8'h5A, 1'b0);
        capture(-1, -1, 8'h00, 1'b1, sym, stab, rl);
        exp = {1'b1, 8'h5A, 1'b0};
        for (int s = 0; s < 10; s++) begin
            checks++;
            if (sym[s] !== exp[s] || stab[s] !== 1'b1) begin
                errors++;
                $display("FAIL toggle_symbol%0d: level=%b held=%b required level=%b held=1", s, sym[s], stab[s], exp[s]);
            end
        end
        want = (sb_q.size() > 0) ? sb_q.pop_front() : 8'hxx;
        checks++;
        if (sym[8:1] !== want) begin
            errors++;
            $display("FAIL toggle_byte: got %h required %h", sym[8:1], want);
        end
        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: %0d bytes left, required 0", sb_q.size());
        end
    endtask

    initial begin
        errors = 0;
        checks = 0;
        test_reset();
        test_a5();
        test_ignore_busy();
        test_back_to_back();
        test_async_reset();
        test_data_toggle();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/uart_transmitter.md
UART_TRANSMITTER -- requirements
Module: uart_transmitter

Interface
REQ-001 Parameter: CLOCK_FREQ, default 125_000_000, clock frequency in Hz.
REQ-002 Parameter: BAUD_RATE, default 115_200, line rate in bits/s.
REQ-003 Derived: T = CLOCK_FREQ / BAUD_RATE (integer division), clock cycles per symbol; T >= 2 SHALL hold, otherwise elaboration error.
REQ-004 clk  input  1  sole clock; all state SHALL update on the rising edge.
REQ-005 rst  input  1  reset, asynchronous and active-high.
REQ-006 data_in  input  8  byte to transmit, sampled only at acceptance.
REQ-007 data_in_valid  input  1  producer (core MMIO store path) offers data_in.
REQ-008 data_in_ready  output  1  transmitter can accept a byte this cycle.
REQ-009 serial_out  output  1  UART line, idle high, registered (no combinational path from any input).

Function
REQ-010 Frame format SHALL be 8N1: one start bit (0), 8 data bits LSB first, one stop bit (1), no parity.
REQ-011 Each symbol SHALL be driven for exactly T clock cycles.
REQ-012 FSM states SHALL be IDLE, START, DATA, STOP.
  - IDLE -> START on acceptance.
  - START -> DATA after T cycles.
  - DATA -> STOP after 8*T cycles.
  - STOP -> IDLE after T cycles.
REQ-013 data_in_ready SHALL be 1 exactly when the state is IDLE.
REQ-014 Acceptance SHALL occur on a rising edge where data_in_valid && data_in_ready; data_in is latched into an internal shift register at that edge.
REQ-015 For an acceptance at edge k, serial_out SHALL be:
  - 0 for cycles k+1 .. k+T;
  - data bit i for cycles k+1+(i+1)T .. k+(i+2)T;
  - 1 (stop) for cycles k+1+9T .. k+10T.
REQ-016 data_in_ready SHALL return to 1 in cycle k+1+10T, so the minimum start-to-start spacing is 10T+1 cycles, with one idle-high cycle between back-to-back frames.
REQ-017 data_in_valid while data_in_ready=0 SHALL be ignored: no queuing, no effect on the frame in progress.
REQ-018 Changes on data_in after acceptance SHALL NOT affect the frame in progress.
REQ-019 serial_out SHALL be 1 in IDLE and in STOP.
REQ-020 Cycle counter: width clog2(T); counts 0..T-1 and wraps to 0 at each symbol boundary.
REQ-021 Bit counter: 3 bits; counts 0..7 in DATA and SHALL wrap to 0 on the DATA->STOP transition.
REQ-022 serial_out SHALL be glitch-free: it changes only at symbol boundaries.

Reset
REQ-023 On rst=1, asynchronously and regardless of clk:
  - state = IDLE;
  - serial_out = 1;
  - data_in_ready = 1;
  - cycle counter, bit counter and shift register = 0.
REQ-024 Reset asserted mid-frame SHALL abandon the frame immediately; the line returns high with no partial stop-bit sequence.
REQ-025 The first acceptance SHALL be possible on the first rising edge after rst deasserts.

Verification (CLOCK_FREQ=1000, BAUD_RATE=100, so T=10)
REQ-026 Reset only -> serial_out=1 and data_in_ready=1 throughout; no transitions for 200 cycles.
REQ-027 Send 0xA5 (valid for one cycle):
  - serial_out SHALL be 0,1,0,1,0,0,1,0,1,1, each held 10 cycles;
  - data_in_ready SHALL be 0 for exactly 100 cycles.
REQ-028 Send 0x3C, then assert valid with 0xFF during bit 4 -> line carries only the 0x3C frame; 0xFF is never transmitted.
REQ-029 Valid held high with 0x00 then 0xFF back-to-back:
  - two frames, each start bit 10 cycles;
  - exactly one idle-high cycle between the 0x00 stop bit and the 0xFF start bit;
  - second acceptance occurs at k+101.
REQ-030 Assert rst asynchronously (between clock edges) during data bit 3 of 0x00 -> serial_out=1 and data_in_ready=1 before the next edge; a subsequent 0x81 frame is transmitted correctly.
REQ-031 Toggle data_in every cycle after accepting 0x5A -> received frame bits equal 0x5A.
